// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - 32-entry MIPS register file with per-register busy scoreboard
// Optional same-cycle write-through of data and busy state: define REGFILE_BYPASS_EN.
module register_file_sb #(
    parameter int          N        = 32,
    parameter int          SP_INDEX = 29,
    parameter logic [31:0] SP_RESET = 32'h7FFF_EFFC,
    parameter int          GP_INDEX = 28,
    parameter logic [31:0] GP_RESET = 32'h1000_8000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         RegWrite,
    input  logic [4:0]   WriteRegister,
    input  logic [N-1:0] WriteData,
    input  logic         IssueValid,
    input  logic [4:0]   IssueDest,
    input  logic [4:0]   ReadRegister1,
    input  logic [4:0]   ReadRegister2,
    output logic [N-1:0] ReadData1,
    output logic [N-1:0] ReadData2,
    output logic         Busy1,
    output logic         Busy2,
    output logic [5:0]   PendingCount
);

    logic [N-1:0] regs_q [32];
    logic [N-1:0] regs_d [32];
    logic [31:0]  busy_q;
    logic [31:0]  busy_d;
    logic [5:0]   pending_q;
    logic [5:0]   pending_d;

    logic         wr_en;
    logic         iss_en;
    logic [31:0]  wr_onehot;
    logic [31:0]  iss_onehot;
    logic [31:0]  busy_rise;
    logic [31:0]  busy_fall;

    assign wr_en  = RegWrite && (WriteRegister != 5'd0);
    assign iss_en = IssueValid && (IssueDest != 5'd0);

    always_comb begin
        wr_onehot  = '0;
        iss_onehot = '0;
        if (wr_en) begin
            wr_onehot[WriteRegister] = 1'b1;
        end
        if (iss_en) begin
            iss_onehot[IssueDest] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en) begin
            regs_d[WriteRegister] = WriteData;
        end
    end

    // Set beats clear on the same index: the newer producer is still outstanding.
    always_comb begin
        busy_d    = (busy_q & ~wr_onehot) | iss_onehot;
        busy_d[0] = 1'b0;
        busy_rise = busy_d & ~busy_q;
        busy_fall = busy_q & ~busy_d;
    end

    // At most one bit can rise and one can fall per edge, so the count moves by -1, 0 or +1.
    always_comb begin
        pending_d = pending_q;
        if ((|busy_rise) && !(|busy_fall)) begin
            pending_d = pending_q + 6'd1;
        end else if (!(|busy_rise) && (|busy_fall)) begin
            pending_d = pending_q - 6'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                if (i == SP_INDEX) begin
                    regs_q[i] <= N'(SP_RESET);
                end else if (i == GP_INDEX) begin
                    regs_q[i] <= N'(GP_RESET);
                end else begin
                    regs_q[i] <= '0;
                end
            end
            busy_q    <= '0;
            pending_q <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
            regs_q[0] <= '0;
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end

    assign PendingCount = pending_q;

`ifdef REGFILE_BYPASS_EN
    logic byp1;
    logic byp2;

    assign byp1 = wr_en && (WriteRegister == ReadRegister1);
    assign byp2 = wr_en && (WriteRegister == ReadRegister2);

    always_comb begin
        ReadData1 = (ReadRegister1 == 5'd0) ? '0 : (byp1 ? WriteData : regs_q[ReadRegister1]);
        ReadData2 = (ReadRegister2 == 5'd0) ? '0 : (byp2 ? WriteData : regs_q[ReadRegister2]);
        Busy1     = byp1 ? iss_onehot[ReadRegister1] : busy_q[ReadRegister1];
        Busy2     = byp2 ? iss_onehot[ReadRegister2] : busy_q[ReadRegister2];
    end
`else
    always_comb begin
        ReadData1 = (ReadRegister1 == 5'd0) ? '0 : regs_q[ReadRegister1];
        ReadData2 = (ReadRegister2 == 5'd0) ? '0 : regs_q[ReadRegister2];
        Busy1     = busy_q[ReadRegister1];
        Busy2     = busy_q[ReadRegister2];
    end
`endif

endmodule

// File: tb/tb_register_file_sb.sv
// tb/tb_register_file_sb.sv - directed self-checking bench for register_file_sb
module tb_register_file_sb;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        IssueValid;
    logic [4:0]  IssueDest;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic        Busy1;
    logic        Busy2;
    logic [5:0]  PendingCount;

    int total;
    int bad;

    register_file_sb dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .IssueValid    (IssueValid),
        .IssueDest     (IssueDest),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .Busy1         (Busy1),
        .Busy2         (Busy2),
        .PendingCount  (PendingCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegWrite   = 1'b0;
        IssueValid = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        idle();
        WriteRegister = '0;
        WriteData     = '0;
        IssueDest     = '0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        #12 reset = 1'b1;
        #1;

        ReadRegister1 = 5'd0;  ReadRegister2 = 5'd28; #1;
        check("rst_r0",  ReadData1, 32'h0);
        check("rst_r28", ReadData2, 32'h1000_8000);
        ReadRegister1 = 5'd29; ReadRegister2 = 5'd5; #1;
        check("rst_r29", ReadData1, 32'h7FFF_EFFC);
        check("rst_r5",  ReadData2, 32'h0);
        check("rst_cnt", 32'(PendingCount), 32'd0);
        check("rst_b1",  32'(Busy1), 32'd0);

        RegWrite = 1'b1; WriteRegister = 5'd0; WriteData = 32'hDEAD_BEEF; tick();
        WriteRegister = 5'd8; tick();
        idle(); ReadRegister1 = 5'd0; ReadRegister2 = 5'd8; #1;
        check("wr_r0", ReadData1, 32'h0);
        check("wr_r8", ReadData2, 32'hDEAD_BEEF);

        IssueValid = 1'b1; IssueDest = 5'd0; tick();
        idle(); ReadRegister1 = 5'd0; #1;
        check("r0_busy", 32'(Busy1), 32'd0);
        check("r0_cnt",  32'(PendingCount), 32'd0);

        IssueValid = 1'b1; IssueDest = 5'd9; tick();
        idle(); ReadRegister1 = 5'd9; #1;
        check("iss9_busy", 32'(Busy1), 32'd1);
        check("iss9_cnt",  32'(PendingCount), 32'd1);
        RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 32'h1234; tick();
        idle(); #1;
        check("wb9_busy", 32'(Busy1), 32'd0);
        check("wb9_data", ReadData1, 32'h1234);
        check("wb9_cnt",  32'(PendingCount), 32'd0);

        IssueValid = 1'b1; IssueDest = 5'd10;
        RegWrite = 1'b1; WriteRegister = 5'd10; WriteData = 32'hA; tick();
        idle(); ReadRegister1 = 5'd10; #1;
        check("same10_busy", 32'(Busy1), 32'd1);
        check("same10_cnt",  32'(PendingCount), 32'd1);

        IssueValid = 1'b1; IssueDest = 5'd12; tick();
        idle(); #1;
        check("iss12_cnt", 32'(PendingCount), 32'd2);
        IssueValid = 1'b1; IssueDest = 5'd11;
        RegWrite = 1'b1; WriteRegister = 5'd12; WriteData = 32'hC; tick();
        idle(); ReadRegister1 = 5'd11; ReadRegister2 = 5'd12; #1;
        check("swap_cnt", 32'(PendingCount), 32'd2);
        check("swap_b11", 32'(Busy1), 32'd1);
        check("swap_b12", 32'(Busy2), 32'd0);

        IssueValid = 1'b1; IssueDest = 5'd10; tick();
        idle(); #1;
        check("reiss_cnt", 32'(PendingCount), 32'd2);
        RegWrite = 1'b1; WriteRegister = 5'd13; WriteData = 32'hD; tick();
        idle(); ReadRegister1 = 5'd13; #1;
        check("clr_idle_cnt", 32'(PendingCount), 32'd2);
        check("clr_idle_dat", ReadData1, 32'hD);

        ReadRegister2 = 5'd7;
        RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 32'hCAFE; #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_same", ReadData2, 32'hCAFE);
`else
        check("byp_same", ReadData2, 32'h0);
`endif
        check("byp_busy", 32'(Busy2), 32'd0);
        tick();
        idle(); #1;
        check("byp_next", ReadData2, 32'hCAFE);

        IssueValid = 1'b1; IssueDest = 5'd1; tick();
        IssueDest = 5'd2; tick();
        IssueDest = 5'd3; tick();
        idle(); ReadRegister1 = 5'd2; ReadRegister2 = 5'd8; #1;
        check("pre_rst_cnt",  32'(PendingCount), 32'd5);
        check("pre_rst_busy", 32'(Busy1), 32'd1);
        #2 reset = 1'b0; #1;
        check("mid_rst_cnt",  32'(PendingCount), 32'd0);
        check("mid_rst_busy", 32'(Busy1), 32'd0);
        check("mid_rst_r8",   ReadData2, 32'h0);
        ReadRegister1 = 5'd29; ReadRegister2 = 5'd28; #1;
        check("mid_rst_r29", ReadData1, 32'h7FFF_EFFC);
        check("mid_rst_r28", ReadData2, 32'h1000_8000);

        RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 32'h5555;
        IssueValid = 1'b1; IssueDest = 5'd5; tick();
        idle(); reset = 1'b1; ReadRegister1 = 5'd5; #1;
        check("rst_wr_lost",  ReadData1, 32'h0);
        check("rst_iss_lost", 32'(Busy1), 32'd0);
        tick();
        check("post_rst_cnt", 32'(PendingCount), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
